pmci_axi_id_tracker: RTL and testbench
======================================

# pmci_axi_id_tracker

Sits between the PMCI subsystem AXI4 master port and the AXI4-lite CSR fabric. It carries the write and read channels through to the fabric and keeps the AWID/ARID of each accepted request in per-direction in-order FIFOs. Each BID/RID is returned from the head of its FIFO, so up to MAX_OUTST requests per direction can be outstanding. This replaces single-register ID latching, which fails once a second request is issued before the first response returns.

## Interface
Parameters:
- ID_W, 8, AXI ID width
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- MAX_OUTST, 4, maximum outstanding requests per direction; power of 2, 2..16

Ports:
- clk_csr  in  1  CSR clock; the block's only clock
- rst_n_csr  in  1  asynchronous, active-low reset
- s_awid/s_awaddr/s_awprot/s_awvalid  in  ID_W/ADDR_W/3/1  write address from the PMCI master
- s_awready  out  1
- s_wdata/s_wstrb/s_wvalid  in  DATA_W/DATA_W/8/1; s_wready  out  1
- s_bid/s_bresp/s_bvalid  out  ID_W/2/1; s_bready  in  1
- s_arid/s_araddr/s_arprot/s_arvalid  in  ID_W/ADDR_W/3/1; s_arready  out  1
- s_rid/s_rdata/s_rresp/s_rvalid  out  ID_W/DATA_W/2/1; s_rready  in  1
- m_aw*/m_w*/m_ar* (no ID)  out, with m_awready/m_wready/m_arready  in: AXI4-lite requests to the fabric
- m_bresp/m_bvalid, m_rdata/m_rresp/m_rvalid  in; m_bready, m_rready  out
- wr_outst  out  $clog2(MAX_OUTST)+1  write IDs currently held
- rd_outst  out  $clog2(MAX_OUTST)+1  read IDs currently held
- orphan_err  out  2  sticky flags: bit0 = B with no tracked ID, bit1 = R with no tracked ID
- orphan_clr  in  1  synchronous clear of orphan_err

## Operation
- Write ID FIFO: depth MAX_OUTST, registered storage, pointers of $clog2(MAX_OUTST)+1 bits; full when the MSBs differ and the lower bits are equal.
- AW channel: m_awvalid = s_awvalid & !wr_full; s_awready = m_awready & !wr_full. Address and prot pass through. On s_awvalid & s_awready, s_awid is pushed.
- W channel: pure pass-through (valid, ready, data, strb); it is not gated by the FIFO.
- B channel, FIFO non-empty: s_bvalid = m_bvalid, m_bready = s_bready, s_bresp = m_bresp, s_bid = FIFO head. The head is popped on s_bvalid & s_bready.
- B channel, FIFO empty (orphan): s_bvalid = 0 and m_bready = 1, so the response is dropped. orphan_err[0] is set on m_bvalid.
- AR/R channels mirror AW/B with the read ID FIFO. rdata and rresp pass through; s_rid = FIFO head; orphan_err[1] is set on an orphan m_rvalid.
- Push and pop in the same cycle: both happen, and the count is unchanged. When the FIFO is full, a pop in cycle N makes s_awready eligible in cycle N+1; it does not bypass in the same cycle.
- wr_outst and rd_outst each equal push count minus pop count for their FIFO.
- orphan_clr and a set in the same cycle: set wins.
- The two directions are fully independent.

## Timing
- All data paths are combinational, with zero added latency. Only the FIFO pointers, FIFO storage and orphan_err are registered.
- Reset (asynchronous assert, synchronous deassert assumed upstream): pointers go to 0, wr_outst = rd_outst = 0, orphan_err = 0.
- While rst_n_csr is low, every valid and ready output is forced to 0: s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready.
- Reset in the middle of a transaction discards all tracked IDs. Responses arriving after reset count as orphans.
- s_bid and s_rid are stable whenever their valid is high, because the head only changes on a pop.
- No combinational path exists from s_bready or s_rready to s_awready or s_arready.

## Test plan
- Single write, awid=0x5A, fabric returns bresp=0 after 3 cycles -> s_bid=0x5A, s_bresp=0; wr_outst goes 1 then 0.
- Four back-to-back reads with arids 1,2,3,4 and MAX_OUTST=4, responses withheld -> rd_outst=4 and s_arready=0 on a fifth request. Return 4 R beats -> s_rid = 1,2,3,4 in order; the fifth AR is accepted the cycle after the first pop.
- FIFO full with a response handshake in cycle N -> s_awready rises in cycle N+1. An AW push and a B pop in the same cycle with wr_outst=2 -> wr_outst stays 2.
- Fabric drives m_bvalid with no outstanding write -> m_bready=1, s_bvalid=0, orphan_err=2'b01. Pulse orphan_clr -> 0. A set and clear in the same cycle -> stays 1.
- Issue 3 writes, then assert rst_n_csr low mid-response -> all valid/ready outputs are 0 immediately, and wr_outst=0 after release.
- Interleave writes (ids 0x10, 0x11) with reads (ids 0x20, 0x21), with B and R returning concurrently under random s_bready/s_rready backpressure -> IDs stay correct per channel and no response is lost or duplicated.

Source files
------------

// File: rtl/pmci_axi_id_tracker_if.sv
// PMCI AXI4 master side and AXI4-lite CSR fabric side
// signal bundle for the ID tracker.
interface pmci_axi_id_tracker_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [2:0]          s_awprot;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ID_W-1:0]     s_arid;
  logic [ADDR_W-1:0]   s_araddr;
  logic [2:0]          s_arprot;
  logic                s_arvalid;
  logic                s_arready;
  logic [ID_W-1:0]     s_rid;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  logic [ADDR_W-1:0]   m_awaddr;
  logic [2:0]          m_awprot;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [ADDR_W-1:0]   m_araddr;
  logic [2:0]          m_arprot;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awprot, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arprot, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rvalid,
    input  s_rready,
    output m_awaddr, m_awprot, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arprot, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awprot, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arprot, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rvalid,
    output s_rready,
    input  m_awaddr, m_awprot, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arprot, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/pmci_axi_id_tracker.sv
// AXI4 -> AXI4-lite bridge keeping AWID/ARID in
// per-direction in-order FIFOs for BID/RID return.
module pmci_axi_id_tracker #(
  parameter int ID_W      = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4,
  localparam int PW       = $clog2(MAX_OUTST) + 1
) (
  input  logic                   clk_csr,
  input  logic                   rst_n_csr,
  pmci_axi_id_tracker_if.slave   bus,
  output logic [PW-1:0]          wr_outst,
  output logic [PW-1:0]          rd_outst,
  output logic [1:0]             orphan_err,
  input  logic                   orphan_clr
);
  localparam int AW = PW - 1;

  logic [ADDR_W-1:0]   awaddr;
  logic [ADDR_W-1:0]   araddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W/8-1:0] wstrb;

  logic [PW-1:0]   wwp, wrp, rwp, rrp;
  logic [ID_W-1:0] wmem [MAX_OUTST];
  logic [ID_W-1:0] rmem [MAX_OUTST];

  logic wr_full, wr_empty, rd_full, rd_empty;
  logic wr_push, wr_pop, rd_push, rd_pop;
  logic [1:0] orph_set;

  assign wr_empty = (wwp == wrp);
  assign rd_empty = (rwp == rrp);
  assign wr_full  = (wwp[AW] != wrp[AW]) &&
                    (wwp[AW-1:0] == wrp[AW-1:0]);
  assign rd_full  = (rwp[AW] != rrp[AW]) &&
                    (rwp[AW-1:0] == rrp[AW-1:0]);

  // Write address and data
  assign awaddr         = bus.s_awaddr;
  assign bus.m_awaddr   = awaddr;
  assign bus.m_awprot   = bus.s_awprot;
  assign bus.m_awvalid  = rst_n_csr & bus.s_awvalid
                        & ~wr_full;
  assign bus.s_awready  = rst_n_csr & bus.m_awready
                        & ~wr_full;
  assign wdata          = bus.s_wdata;
  assign wstrb          = bus.s_wstrb;
  assign bus.m_wdata    = wdata;
  assign bus.m_wstrb    = wstrb;
  assign bus.m_wvalid   = rst_n_csr & bus.s_wvalid;
  assign bus.s_wready   = rst_n_csr & bus.m_wready;

  // Empty FIFO means an orphan: sink it on the fabric side
  assign bus.s_bid      = wmem[wrp[AW-1:0]];
  assign bus.s_bresp    = bus.m_bresp;
  assign bus.s_bvalid   = rst_n_csr & ~wr_empty
                        & bus.m_bvalid;
  assign bus.m_bready   = rst_n_csr
                        & (wr_empty | bus.s_bready);

  assign araddr         = bus.s_araddr;
  assign bus.m_araddr   = araddr;
  assign bus.m_arprot   = bus.s_arprot;
  assign bus.m_arvalid  = rst_n_csr & bus.s_arvalid
                        & ~rd_full;
  assign bus.s_arready  = rst_n_csr & bus.m_arready
                        & ~rd_full;

  assign rdata          = bus.m_rdata;
  assign bus.s_rdata    = rdata;
  assign bus.s_rid      = rmem[rrp[AW-1:0]];
  assign bus.s_rresp    = bus.m_rresp;
  assign bus.s_rvalid   = rst_n_csr & ~rd_empty
                        & bus.m_rvalid;
  assign bus.m_rready   = rst_n_csr
                        & (rd_empty | bus.s_rready);

  assign wr_push = bus.s_awvalid & bus.s_awready;
  assign wr_pop  = bus.s_bvalid & bus.s_bready;
  assign rd_push = bus.s_arvalid & bus.s_arready;
  assign rd_pop  = bus.s_rvalid & bus.s_rready;

  assign orph_set[0] = wr_empty & bus.m_bvalid;
  assign orph_set[1] = rd_empty & bus.m_rvalid;

  assign wr_outst = wwp - wrp;
  assign rd_outst = rwp - rrp;

  always_ff @(posedge clk_csr or negedge rst_n_csr) begin
    if (!rst_n_csr) begin
      wwp <= '0;
      wrp <= '0;
      rwp <= '0;
      rrp <= '0;
    end else begin
      if (wr_push) wwp <= wwp + PW'(1);
      if (wr_pop)  wrp <= wrp + PW'(1);
      if (rd_push) rwp <= rwp + PW'(1);
      if (rd_pop)  rrp <= rrp + PW'(1);
    end
  end

  always_ff @(posedge clk_csr) begin
    if (wr_push) wmem[wwp[AW-1:0]] <= bus.s_awid;
    if (rd_push) rmem[rwp[AW-1:0]] <= bus.s_arid;
  end

  // Set has priority over clear
  always_ff @(posedge clk_csr or negedge rst_n_csr) begin
    if (!rst_n_csr) begin
      orphan_err <= '0;
    end else begin
      orphan_err <= orph_set
                  | (orphan_err & {2{~orphan_clr}});
    end
  end
endmodule

// File: tb/tb_pmci_axi_id_tracker.sv
// Directed bench for pmci_axi_id_tracker: vector table
// plus sequences for full, reset and interleaved traffic.
module tb_pmci_axi_id_tracker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wr_outst, rd_outst;
  logic [1:0] orphan_err;
  logic       orphan_clr;

  int total = 0;
  int bad = 0;

  pmci_axi_id_tracker_if #(
    .ID_W(8), .ADDR_W(32), .DATA_W(64)
  ) bus ();

  pmci_axi_id_tracker #(
    .ID_W(8), .ADDR_W(32), .DATA_W(64),
    .MAX_OUTST(4)
  ) dut (
    .clk_csr   (clk),
    .rst_n_csr (rst_n),
    .bus       (bus),
    .wr_outst  (wr_outst),
    .rd_outst  (rd_outst),
    .orphan_err(orphan_err),
    .orphan_clr(orphan_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int awv, awid, mawr, mbv, sbr;
    int arv, arid, marr, mrv, srr, clr;
    int e_awr, e_mawv, e_bv, e_bid, e_mbr;
    int e_arr, e_marv, e_rv, e_rid, e_mrr;
    int e_wo, e_ro, e_orph;
  } vec_t;

  vec_t vt [25];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.s_awid = '0;    bus.s_awaddr = '0;
    bus.s_awprot = '0;  bus.s_awvalid = 1'b0;
    bus.s_wdata = '0;   bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
    bus.s_arid = '0;    bus.s_araddr = '0;
    bus.s_arprot = '0;  bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    bus.m_bresp = '0;   bus.m_bvalid = 1'b0;
    bus.m_arready = 1'b0; bus.m_rdata = '0;
    bus.m_rresp = '0;   bus.m_rvalid = 1'b0;
    orphan_clr = 1'b0;
  endtask

  initial begin
    int bq [2];
    int rq [2];
    int bdone, rdone, cyc;
    idle();
    //       awv awid mawr mbv sbr arv arid marr mrv srr clr
    //       awr mawv bv bid mbr arr marv rv rid mrr wo ro or
    vt[0]  = '{1,'h5A,1,0,0, 0,0,0,0,0, 0,
               1,1,0,-1,1, 0,0,0,-1,1, 1,0,0};
    vt[1]  = '{0,0,0,0,0, 0,0,0,0,0, 0,
               0,0,0,-1,0, 0,0,0,-1,1, 1,0,0};
    vt[2]  = '{0,0,0,0,0, 0,0,0,0,0, 0,
               0,0,0,-1,0, 0,0,0,-1,1, 1,0,0};
    vt[3]  = '{0,0,0,1,1, 0,0,0,0,0, 0,
               0,0,1,'h5A,1, 0,0,0,-1,1, 0,0,0};
    vt[4]  = '{0,0,0,1,0, 0,0,0,0,0, 0,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,1};
    vt[5]  = '{0,0,0,0,0, 0,0,0,0,0, 1,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,0};
    vt[6]  = '{0,0,0,1,0, 0,0,0,0,0, 1,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,1};
    vt[7]  = '{0,0,0,0,0, 0,0,0,0,0, 1,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,0};
    vt[8]  = '{0,0,0,0,0, 0,0,0,1,0, 0,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,2};
    vt[9]  = '{0,0,0,0,0, 0,0,0,0,0, 1,
               0,0,0,-1,1, 0,0,0,-1,1, 0,0,0};
    vt[10] = '{1,'h10,1,0,0, 0,0,0,0,0, 0,
               1,1,0,-1,1, 0,0,0,-1,1, 1,0,0};
    vt[11] = '{1,'h11,1,0,0, 0,0,0,0,0, 0,
               1,1,0,-1,0, 0,0,0,-1,1, 2,0,0};
    vt[12] = '{1,'h12,1,1,1, 0,0,0,0,0, 0,
               1,1,1,'h10,1, 0,0,0,-1,1, 2,0,0};
    vt[13] = '{0,0,0,1,1, 0,0,0,0,0, 0,
               0,0,1,'h11,1, 0,0,0,-1,1, 1,0,0};
    vt[14] = '{0,0,0,1,1, 0,0,0,0,0, 0,
               0,0,1,'h12,1, 0,0,0,-1,1, 0,0,0};
    vt[15] = '{0,0,0,0,0, 1,1,1,0,0, 0,
               0,0,0,-1,1, 1,1,0,-1,1, 0,1,0};
    vt[16] = '{0,0,0,0,0, 1,2,1,0,0, 0,
               0,0,0,-1,1, 1,1,0,-1,0, 0,2,0};
    vt[17] = '{0,0,0,0,0, 1,3,1,0,0, 0,
               0,0,0,-1,1, 1,1,0,-1,0, 0,3,0};
    vt[18] = '{0,0,0,0,0, 1,4,1,0,0, 0,
               0,0,0,-1,1, 1,1,0,-1,0, 0,4,0};
    vt[19] = '{0,0,0,0,0, 1,5,1,0,0, 0,
               0,0,0,-1,1, 0,0,0,-1,0, 0,4,0};
    vt[20] = '{0,0,0,0,0, 1,5,1,1,1, 0,
               0,0,0,-1,1, 0,0,1,1,1, 0,3,0};
    vt[21] = '{0,0,0,0,0, 1,5,1,1,1, 0,
               0,0,0,-1,1, 1,1,1,2,1, 0,3,0};
    vt[22] = '{0,0,0,0,0, 0,0,0,1,1, 0,
               0,0,0,-1,1, 0,0,1,3,1, 0,2,0};
    vt[23] = '{0,0,0,0,0, 0,0,0,1,1, 0,
               0,0,0,-1,1, 0,0,1,4,1, 0,1,0};
    vt[24] = '{0,0,0,0,0, 0,0,0,1,1, 0,
               0,0,0,-1,1, 0,0,1,5,1, 0,0,0};

    // reset state
    #1;
    chk("rst ready/valid",
        64'({bus.s_awready, bus.s_bvalid,
             bus.m_bready, bus.s_arready,
             bus.s_rvalid, bus.m_rready}), 64'(0));
    chk("rst wr_outst", 64'(wr_outst), 64'(0));
    chk("rst orphan", 64'(orphan_err), 64'(0));
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      bus.s_awvalid = vt[i].awv[0];
      bus.s_awid    = vt[i].awid[7:0];
      bus.m_awready = vt[i].mawr[0];
      bus.m_bvalid  = vt[i].mbv[0];
      bus.s_bready  = vt[i].sbr[0];
      bus.s_arvalid = vt[i].arv[0];
      bus.s_arid    = vt[i].arid[7:0];
      bus.m_arready = vt[i].marr[0];
      bus.m_rvalid  = vt[i].mrv[0];
      bus.s_rready  = vt[i].srr[0];
      orphan_clr    = vt[i].clr[0];
      #1;
      chk($sformatf("v%0d s_awready", i),
          64'(bus.s_awready), 64'(vt[i].e_awr));
      chk($sformatf("v%0d m_awvalid", i),
          64'(bus.m_awvalid), 64'(vt[i].e_mawv));
      chk($sformatf("v%0d s_bvalid", i),
          64'(bus.s_bvalid), 64'(vt[i].e_bv));
      if (vt[i].e_bid >= 0)
        chk($sformatf("v%0d s_bid", i),
            64'(bus.s_bid), 64'(vt[i].e_bid));
      chk($sformatf("v%0d m_bready", i),
          64'(bus.m_bready), 64'(vt[i].e_mbr));
      chk($sformatf("v%0d s_arready", i),
          64'(bus.s_arready), 64'(vt[i].e_arr));
      chk($sformatf("v%0d m_arvalid", i),
          64'(bus.m_arvalid), 64'(vt[i].e_marv));
      chk($sformatf("v%0d s_rvalid", i),
          64'(bus.s_rvalid), 64'(vt[i].e_rv));
      if (vt[i].e_rid >= 0)
        chk($sformatf("v%0d s_rid", i),
            64'(bus.s_rid), 64'(vt[i].e_rid));
      chk($sformatf("v%0d m_rready", i),
          64'(bus.m_rready), 64'(vt[i].e_mrr));
      @(posedge clk); #1;
      chk($sformatf("v%0d wr_outst", i),
          64'(wr_outst), 64'(vt[i].e_wo));
      chk($sformatf("v%0d rd_outst", i),
          64'(rd_outst), 64'(vt[i].e_ro));
      chk($sformatf("v%0d orphan_err", i),
          64'(orphan_err), 64'(vt[i].e_orph));
    end

    // pass-through of address, data, strobe, resp
    @(negedge clk); idle();
    bus.s_awaddr = 32'hDEAD_BEE0;
    bus.s_awprot = 3'd5;
    bus.s_wdata  = 64'h0123_4567_89AB_CDEF;
    bus.s_wstrb  = 8'hA5;
    bus.s_wvalid = 1'b1;
    bus.m_wready = 1'b1;
    bus.s_araddr = 32'h0000_1234;
    bus.m_rdata  = 64'hFEDC_BA98_7654_3210;
    bus.m_rresp  = 2'd2;
    bus.m_bresp  = 2'd3;
    #1;
    chk("m_awaddr", 64'(bus.m_awaddr), 64'hDEAD_BEE0);
    chk("m_awprot", 64'(bus.m_awprot), 64'd5);
    chk("m_wdata", bus.m_wdata, 64'h0123_4567_89AB_CDEF);
    chk("m_wstrb", 64'(bus.m_wstrb), 64'hA5);
    chk("w valid/ready",
        64'({bus.m_wvalid, bus.s_wready}), 64'(3));
    chk("m_araddr", 64'(bus.m_araddr), 64'h1234);
    chk("s_rdata", bus.s_rdata, 64'hFEDC_BA98_7654_3210);
    chk("s_rresp", 64'(bus.s_rresp), 64'd2);
    chk("s_bresp", 64'(bus.s_bresp), 64'd3);

    // write FIFO full, pop in N, awready in N+1
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      bus.s_awvalid = 1'b1;
      bus.s_awid    = 8'hA0 + 8'(k);
      bus.m_awready = 1'b1;
    end
    @(negedge clk);
    bus.s_awid = 8'hA4;
    #1;
    chk("full awready", 64'(bus.s_awready), 64'(0));
    chk("full wr_outst", 64'(wr_outst), 64'(4));
    @(negedge clk);
    bus.m_bvalid = 1'b1; bus.s_bready = 1'b1;
    #1;
    chk("pop N awready", 64'(bus.s_awready), 64'(0));
    chk("pop N bid", 64'(bus.s_bid), 64'hA0);
    @(negedge clk);
    bus.m_bvalid = 1'b0; bus.s_bready = 1'b0;
    #1;
    chk("N+1 awready", 64'(bus.s_awready), 64'(1));
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      bus.m_bvalid = 1'b1; bus.s_bready = 1'b1;
      #1;
      chk($sformatf("drain bid %0d", k),
          64'(bus.s_bid), 64'(8'hA0 + 8'(k)));
      @(negedge clk);
    end
    idle(); #1;
    chk("drained wr_outst", 64'(wr_outst), 64'(0));

    // reset in the middle of a response
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle();
      bus.s_awvalid = 1'b1;
      bus.s_awid    = 8'h30 + 8'(k);
      bus.m_awready = 1'b1;
    end
    @(negedge clk);
    bus.s_wvalid = 1'b1;  bus.m_wready = 1'b1;
    bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
    bus.m_bvalid = 1'b1;  bus.m_rvalid = 1'b1;
    #2; rst_n = 1'b0; #1;
    chk("mid rst outputs",
        64'({bus.s_awready, bus.s_wready,
             bus.s_arready, bus.s_bvalid,
             bus.s_rvalid, bus.m_awvalid,
             bus.m_wvalid, bus.m_arvalid,
             bus.m_bready, bus.m_rready}), 64'(0));
    @(negedge clk); idle();
    bus.m_bvalid = 1'b1;
    rst_n = 1'b1; #1;
    chk("post rst wr_outst", 64'(wr_outst), 64'(0));
    chk("post rst bvalid", 64'(bus.s_bvalid), 64'(0));
    chk("post rst bready", 64'(bus.m_bready), 64'(1));
    @(posedge clk); #1;
    chk("post rst orphan", 64'(orphan_err), 64'(1));
    @(negedge clk); idle(); orphan_clr = 1'b1;
    @(negedge clk); orphan_clr = 1'b0;

    // interleaved traffic with random backpressure
    bq = '{'h10, 'h11};
    rq = '{'h20, 'h21};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle();
      bus.s_awvalid = 1'b1; bus.m_awready = 1'b1;
      bus.s_awid = 8'(bq[k]);
      bus.s_arvalid = 1'b1; bus.m_arready = 1'b1;
      bus.s_arid = 8'(rq[k]);
    end
    bdone = 0; rdone = 0; cyc = 0;
    while ((bdone < 2 || rdone < 2) && cyc < 200) begin
      @(negedge clk); idle();
      bus.m_bvalid = (bdone < 2);
      bus.m_rvalid = (rdone < 2);
      bus.s_bready = 1'($urandom_range(0, 1));
      bus.s_rready = 1'($urandom_range(0, 1));
      #1;
      if (bus.s_bvalid && bus.s_bready) begin
        chk($sformatf("mix bid %0d", bdone),
            64'(bus.s_bid), 64'(bq[bdone]));
        bdone++;
      end
      if (bus.s_rvalid && bus.s_rready) begin
        chk($sformatf("mix rid %0d", rdone),
            64'(bus.s_rid), 64'(rq[rdone]));
        rdone++;
      end
      cyc++;
    end
    chk("mix b count", 64'(bdone), 64'(2));
    chk("mix r count", 64'(rdone), 64'(2));
    @(negedge clk); idle();
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    @(posedge clk); #1;
    chk("mix wr_outst", 64'(wr_outst), 64'(0));
    chk("mix rd_outst", 64'(rd_outst), 64'(0));
    chk("mix orphan", 64'(orphan_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
